// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and timed access sequencer for an external async SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN to make port 0 win every tie (port 1 may starve).
module sram_arbiter #(
    parameter int SRAM_DATA_SIZE = 8,
    parameter int SRAM_ADDR_SIZE = 19,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic                      rnw0,
    input  logic [SRAM_ADDR_SIZE-1:0] addr0,
    input  logic [SRAM_DATA_SIZE-1:0] wdat0,
    output logic                      ack0,
    output logic                      done0,
    input  logic                      req1,
    input  logic                      rnw1,
    input  logic [SRAM_ADDR_SIZE-1:0] addr1,
    input  logic [SRAM_DATA_SIZE-1:0] wdat1,
    output logic                      ack1,
    output logic                      done1,
    output logic [SRAM_DATA_SIZE-1:0] rdat,
    output logic                      busy,
    inout  logic [SRAM_DATA_SIZE-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
    output logic                      SRAM_CE_N,
    output logic                      SRAM_OE_N,
    output logic                      SRAM_WE_N
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_END} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("sram_arbiter: WAIT_CYCLES=%0d outside legal range 1..15", WAIT_CYCLES);
    end

    state_t                    state_q, state_d;
    logic [3:0]                wait_q, wait_d;
    logic                      port_q, port_d;
    logic                      rnw_q, rnw_d;
    logic [SRAM_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [SRAM_DATA_SIZE-1:0] wdat_q, wdat_d;
    logic [SRAM_DATA_SIZE-1:0] rdat_q, rdat_d;
    logic                      ack0_q, ack0_d, ack1_q, ack1_d;
    logic                      done0_q, done0_d, done1_q, done1_d;
    logic                      ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                      dq_oe_q, dq_oe_d;
    logic                      busy_q, busy_d;
    logic                      gnt1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic                      last_q, last_d;
`endif

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign gnt1 = req1 & ~req0;
`else
    assign gnt1 = req1 & (~req0 | ~last_q);
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        port_d  = port_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_SETUP;
                    port_d  = gnt1;
                    rnw_d   = gnt1 ? rnw1  : rnw0;
                    addr_d  = gnt1 ? addr1 : addr0;
                    wdat_d  = gnt1 ? wdat1 : wdat0;
                    ack0_d  = ~gnt1;
                    ack1_d  = gnt1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_d  = gnt1;
`endif
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                wait_d  = '0;
            end
            ST_ACCESS: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = ST_END;
                    done0_d = ~port_q;
                    done1_d = port_q;
                    if (rnw_q) begin
                        rdat_d = SRAM_DQ;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so every pin is a flop output.
        ce_n_d  = ~((state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
                    (state_d == ST_END && !rnw_d));
        oe_n_d  = ~(rnw_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)));
        we_n_d  = ~(!rnw_d && (state_d == ST_ACCESS));
        dq_oe_d = !rnw_d && (state_d != ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            port_q  <= 1'b0;
            rnw_q   <= 1'b1;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            busy_q  <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            port_q  <= port_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            busy_q  <= busy_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign SRAM_DQ   = dq_oe_q ? wdat_q : 'z;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdat      = rdat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: behavioural arbitration/memory model feeds expected
// ack/done events into queues; a negedge monitor pops and compares them.
module tb_sram_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, rnw0 = 1'b1, req1 = 1'b0, rnw1 = 1'b1;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdat0 = '0, wdat1 = '0;
    logic          ack0, ack1, done0, done1, busy;
    logic [DW-1:0] rdat;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    wire  [DW-1:0] SRAM_DQ;

    sram_arbiter #(.SRAM_DATA_SIZE(DW), .SRAM_ADDR_SIZE(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rnw0(rnw0), .addr0(addr0), .wdat0(wdat0), .ack0(ack0), .done0(done0),
        .req1(req1), .rnw1(rnw1), .addr1(addr1), .wdat1(wdat1), .ack1(ack1), .done1(done1),
        .rdat(rdat), .busy(busy), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
    );

    // Async SRAM device model: latches writes while WE_N low, drives reads while OE_N low.
    logic [DW-1:0] sram_mem [int];
    logic [DW-1:0] sram_rd = '0;
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? sram_rd : 'z;
    always @(negedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[int'(SRAM_ADDR)] = SRAM_DQ;
        sram_rd = sram_mem.exists(int'(SRAM_ADDR)) ? sram_mem[int'(SRAM_ADDR)] : '0;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int            port;
        int            cyc;
        bit            rd;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t ack_q[$];
    exp_t done_q[$];
    int   act_ports[$];
    int   act_cycs[$];

    // Reference model state
    logic [DW-1:0] ref_mem [int];
    bit            pend [2];
    logic          op_rnw [2];
    logic [AW-1:0] op_addr [2];
    logic [DW-1:0] op_wdat [2];
    int            last_g = 1;
    int            free_cyc = 0;
    int            grant_cnt = 0;
    int            grant_cyc = 0;
    bit            hold_both = 1'b0;
    bit            rand_en = 1'b0;

    task automatic new_op(input int p);
        pend[p]    = 1'b1;
        op_rnw[p]  = 1'($urandom_range(0, 1));
        op_addr[p] = 19'h00100 + 19'($urandom_range(0, 15));
        op_wdat[p] = 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_and_model();
        int   g;
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (!pend[p] && (hold_both || (rand_en && $urandom_range(0, 2) == 0))) new_op(p);
        end
        req0 = pend[0]; rnw0 = op_rnw[0]; addr0 = op_addr[0]; wdat0 = op_wdat[0];
        req1 = pend[1]; rnw1 = op_rnw[1]; addr1 = op_addr[1]; wdat1 = op_wdat[1];
        if (!rst && cyc >= free_cyc && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = 1 - last_g;
`endif
            end else begin
                g = pend[1] ? 1 : 0;
            end
            e.port = g;
            e.rd   = op_rnw[g];
            e.addr = op_addr[g];
            if (op_rnw[g]) begin
                e.data = ref_mem.exists(int'(op_addr[g])) ? ref_mem[int'(op_addr[g])] : '0;
            end else begin
                e.data = op_wdat[g];
                ref_mem[int'(op_addr[g])] = op_wdat[g];
            end
            e.cyc = cyc + 1;
            ack_q.push_back(e);
            e.cyc = cyc + 2 + W;
            done_q.push_back(e);
            last_g    = g;
            free_cyc  = cyc + 3 + W;
            pend[g]   = 1'b0;
            grant_cnt++;
            grant_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            drive_and_model();
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((done_q.size() != 0 || pend[0] || pend[1]) && guard < 300) begin
            run(1);
            guard++;
        end
        run(2);
        chk("drain_bound", 32'(guard < 300), 32'd1);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (3) begin
            tick();
            drive_and_model();
        end
        rst = 1'b0;
        ack_q.delete();
        done_q.delete();
        last_g   = 1;
        free_cyc = cyc;
    endtask

    // Monitor: pops expectations whenever the DUT pulses ack/done, plus bus-safety checks.
    int we_run = 0;
    int oe_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            we_run = 0;
            oe_run = 0;
        end else begin
            if (ack0 || ack1) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 32'({ack1, ack0}), 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_port", 32'({ack1, ack0}), e.port != 0 ? 32'd2 : 32'd1);
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ack_busy", 32'(busy), 32'd1);
                    act_ports.push_back(int'(ack1));
                    act_cycs.push_back(cyc);
                end
            end
            if (done0 || done1) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'({done1, done0}), 32'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_port", 32'({done1, done0}), e.port != 0 ? 32'd2 : 32'd1);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_addr", 32'(SRAM_ADDR), 32'(e.addr));
                    chk("end_ce_n", 32'(SRAM_CE_N), 32'(e.rd));
                    if (e.rd) chk("read_data", 32'(rdat), 32'(e.data));
                    else      chk("write_hold_dq", 32'(SRAM_DQ), 32'(e.data));
                end
            end
            chk("oe_we_exclusive", 32'(SRAM_OE_N | SRAM_WE_N), 32'd1);
            if (SRAM_CE_N) chk("dq_hiz_deselected", 32'(SRAM_DQ === 'z), 32'd1);
            if (!SRAM_WE_N) we_run++;
            else if (we_run != 0) begin
                chk("we_low_width", 32'(we_run), 32'(W));
                we_run = 0;
            end
            if (!SRAM_OE_N) oe_run++;
            else if (oe_run != 0) begin
                chk("oe_low_width", 32'(oe_run), 32'(W + 1));
                oe_run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset state and quiet idle
        do_reset();
        @(negedge clk);
        chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}), 32'h7);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdat", 32'(rdat), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_dq_hiz", 32'(SRAM_DQ === 'z), 32'd1);
        chk("rst_pulses", 32'({ack0, ack1, done0, done1}), 32'd0);
        repeat (10) begin
            run(1);
            @(negedge clk);
            chk("idle_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, busy}), 32'hE);
        end

        // Directed: port 0 writes 0xA5 @ 0x12345, then port 1 reads it back
        pend[0] = 1'b1; op_rnw[0] = 1'b0; op_addr[0] = 19'h12345; op_wdat[0] = 8'hA5;
        drain();
        pend[1] = 1'b1; op_rnw[1] = 1'b1; op_addr[1] = 19'h12345; op_wdat[1] = 8'h00;
        drain();

        // Both ports held from reset: order and ack spacing
        do_reset();
        act_ports.delete();
        act_cycs.delete();
        hold_both = 1'b1;
        base = grant_cnt;
        for (int i = 0; i < 100 && grant_cnt < base + 6; i++) run(1);
        hold_both = 1'b0;
        drain();
        chk("held_ack_count", 32'(act_ports.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < act_ports.size(); i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            chk("held_grant_order", 32'(act_ports[i]), 32'd0);
`else
            chk("held_grant_order", 32'(act_ports[i]), 32'(i % 2));
`endif
            if (i > 0) chk("held_ack_spacing", 32'(act_cycs[i] - act_cycs[i-1]), 32'(3 + W));
        end

        // Reset pulsed during ACCESS of a write: aborted, no done
        pend[0] = 1'b1; op_rnw[0] = 1'b0; op_addr[0] = 19'h7FFFF; op_wdat[0] = 8'h3C;
        base = grant_cnt;
        for (int i = 0; i < 50 && grant_cnt == base; i++) run(1);
        while (cyc < grant_cyc + 2) run(1);
        rst = 1'b1;
        drive_and_model();
        tick();
        rst = 1'b0;
        done_q.delete();
        last_g   = 1;
        free_cyc = cyc;
        drive_and_model();
        @(negedge clk);
        chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("abort_dq_hiz", 32'(SRAM_DQ === 'z), 32'd1);
        chk("abort_done", 32'({done0, done1}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run(6);

        // Randomized traffic from both ports
        rand_en = 1'b1;
        run(500);
        rand_en = 1'b0;
        drain();
        chk("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
